// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared between the instruction-memory loader
// and the processor it feeds.
//   ADDR_W        instruction-memory address width
//   DATA_W        instruction word width (always 4 bytes)
//   DEPTH_DEFAULT number of words the instruction memory holds
//   loader_state_t  boot-loader FSM states
//   be16()        big-endian assembly of a 16-bit length field
package cpu_pkg;

  localparam int ADDR_W        = 9;
  localparam int DATA_W        = 32;
  localparam int DEPTH_DEFAULT = 512;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    DONE,
    ERROR
  } loader_state_t;

  function automatic logic [15:0] be16(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/byte_packer.sv
// byte_packer: collects four stream bytes, MSB first, into one instruction
// word.
//   clock       system clock
//   rst_n       synchronous active-low reset
//   clear       forces the byte counter back to the start of a word
//   byte_valid  a byte is being accepted this cycle
//   byte_data   the byte being accepted
//   word        assembled word, valid together with word_valid
//   word_valid  the byte accepted this cycle completes a word
module byte_packer
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic [DATA_W-1:0] word,
  output logic              word_valid
);

  // The three earlier bytes; the fourth comes straight from the input so the
  // completed word is available in the cycle its last byte is accepted.
  logic [DATA_W-9:0] shreg;
  logic [1:0]        cnt;

  assign word       = {shreg, byte_data};
  assign word_valid = byte_valid && (cnt == 2'd3);

  // NOTE: non-blocking assignments in every clocked block, so all registers
  // update from the values that were present before the edge.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (byte_valid) begin
      cnt <= cnt + 2'd1;
    end
  end

  // NOTE: the shift register is pure datapath and is only observed through
  // word_valid, which depends on the reset counter, so it carries no reset.
  always_ff @(posedge clock) begin
    if (byte_valid) begin
      shreg <= word[DATA_W-9:0];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader in front of the processor's
// instruction-memory write port. Receives a byte stream framed as a 16-bit
// big-endian word count N followed by N big-endian words, writes them to
// addresses 0..N-1, then raises working to release the processor.
//   clock     system clock
//   rst_n     synchronous active-low reset
//   in_valid  stream byte valid
//   in_data   stream byte
//   in_ready  loader can accept a byte
//   reload    one-cycle pulse; restarts a load from DONE or ERROR
//   addr      instruction-memory write address
//   wEn       instruction-memory write enable, one pulse per word
//   wDat      instruction-memory write data
//   working   processor run enable
//   busy      a frame is in progress (after its first byte)
//   err       sticky length error
module imem_loader
  import cpu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic [ADDR_W-1:0] addr,
  output logic              wEn,
  output logic [DATA_W-1:0] wDat,
  output logic              working,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W + 1)'(1);

  loader_state_t     state;
  logic [7:0]        len_hi;
  // One bit wider than the address so a full-depth load does not wrap.
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   word_cnt;

  logic              accept;
  logic [15:0]       len;
  logic [DATA_W-1:0] packed_word;
  logic              packed_valid;

  assign accept = in_valid && in_ready;
  assign len    = be16(len_hi, in_data);

  byte_packer u_packer (
    .clock      (clock),
    .rst_n      (rst_n),
    .clear      (state != DATA),
    .byte_valid (accept && (state == DATA)),
    .byte_data  (in_data),
    .word       (packed_word),
    .word_valid (packed_valid)
  );

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state    <= LEN_HI;
      addr     <= '0;
      wEn      <= 1'b0;
      wDat     <= '0;
      working  <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b0;
      len_hi   <= '0;
      word_idx <= '0;
      word_cnt <= '0;
    end else begin
      // wEn is a single-cycle pulse; only the word-complete branch raises it.
      wEn <= 1'b0;

      unique case (state)
        LEN_HI: begin
          in_ready <= 1'b1;
          if (accept) begin
            len_hi <= in_data;
            busy   <= 1'b1;
            state  <= LEN_LO;
          end
        end

        LEN_LO: begin
          if (accept) begin
            if (len == '0) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
            end else if (len > 16'(DEPTH)) begin
              state    <= ERROR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
            end else begin
              word_cnt <= len[ADDR_W:0];
              word_idx <= '0;
              state    <= DATA;
            end
          end
        end

        DATA: begin
          if (packed_valid) begin
            wEn      <= 1'b1;
            wDat     <= packed_word;
            addr     <= word_idx[ADDR_W-1:0];
            word_idx <= word_idx + IDX_ONE;
            if (word_idx == word_cnt - IDX_ONE) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
            end
          end
        end

        // working follows one cycle behind entry to DONE, so it never
        // overlaps the final write pulse.
        DONE: begin
          if (reload) begin
            working  <= 1'b0;
            in_ready <= 1'b1;
            state    <= LEN_HI;
          end else begin
            working <= 1'b1;
          end
        end

        ERROR: begin
          if (reload) begin
            err      <= 1'b0;
            in_ready <= 1'b1;
            state    <= LEN_HI;
          end
        end

        default: state <= LEN_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. Expected writes are
// queued as frames are streamed and compared against each wEn pulse.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        reload;
  logic [8:0]  addr;
  logic        wEn;
  logic [31:0] wDat;
  logic        working;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [8:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t sb_q[$];

  logic [31:0] prog[$] = '{32'h10f0001c, 32'h10f1001e, 32'h10f20020,
                           32'h10f30022, 32'h10f40024, 32'h10f50026,
                           32'h20100000, 32'h21320000, 32'h32450000};
  logic [31:0] one_q[$] = '{32'h0c000000};
  logic [31:0] empty_q[$];

  imem_loader dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .reload   (reload),
    .addr     (addr),
    .wEn      (wEn),
    .wDat     (wDat),
    .working  (working),
    .busy     (busy),
    .err      (err)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (wEn === 1'b1) begin
      check("wen_while_working", {31'b0, working}, 32'd0);
      if (sb_q.size() == 0) begin
        check("spurious_wen", {31'b0, wEn}, 32'd0);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("wr_addr", {23'b0, addr}, {23'b0, e.a});
        check("wr_data", wDat, e.d);
      end
    end
  end

  // Called at #1 after a posedge; returns at #1 after the edge that accepted.
  task automatic send_byte(input logic [7:0] b, input bit gappy);
    bit acc;
    int guard;
    if (gappy) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clock);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    forever begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      if (acc) break;
      guard++;
      if (guard > 50) begin
        check("accept_timeout", {31'b0, in_ready}, 32'd1);
        break;
      end
    end
  endtask

  task automatic load_stream(input logic [15:0] n, input logic [31:0] words[$],
                             input bit gappy, input int stop_after);
    int limit;
    logic [31:0] w;
    limit = (stop_after < 0) ? words.size() * 4 : stop_after;
    send_byte(n[15:8], gappy);
    check("busy_after_len_hi", {31'b0, busy}, 32'd1);
    send_byte(n[7:0], gappy);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      if (i * 4 + 4 <= limit) sb_q.push_back('{a: 9'(i), d: w});
      for (int b = 0; b < 4; b++) begin
        if (i * 4 + b < limit) send_byte(w[31-8*b -: 8], gappy);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clock);
    #1;
    reload = 1'b0;
    check("reload_working", {31'b0, working}, 32'd0);
    check("reload_err", {31'b0, err}, 32'd0);
    check("reload_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, {23'b0, addr}, 32'd0);
    check({tag, "_wen"}, {31'b0, wEn}, 32'd0);
    check({tag, "_wdat"}, wDat, 32'd0);
    check({tag, "_working"}, {31'b0, working}, 32'd0);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
  endtask

  // Caller is in the cycle holding the final write pulse.
  task automatic check_done(input string tag);
    check({tag, "_last_wen"}, {31'b0, wEn}, 32'd1);
    check({tag, "_working_early"}, {31'b0, working}, 32'd0);
    @(posedge clock);
    #1;
    check({tag, "_working"}, {31'b0, working}, 32'd1);
    check({tag, "_in_ready_done"}, {31'b0, in_ready}, 32'd0);
    check({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
    check({tag, "_sb_empty"}, sb_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    reload   = 1'b0;

    // Reset state, then in_ready rises after release.
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    check("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

    // Reference program at one byte per cycle.
    c0 = cyc;
    load_stream(16'd9, prog, 1'b0, -1);
    check("throughput_cycles", cyc - c0, 32'd38);
    check_done("ref");

    // Same program with random gaps in in_valid.
    pulse_reload();
    load_stream(16'd9, prog, 1'b1, -1);
    check_done("gappy");

    // Empty program: no writes, working two cycles after the second byte.
    pulse_reload();
    load_stream(16'd0, empty_q, 1'b0, -1);
    check("zero_in_ready", {31'b0, in_ready}, 32'd0);
    check("zero_working_early", {31'b0, working}, 32'd0);
    @(posedge clock);
    #1;
    check("zero_working", {31'b0, working}, 32'd1);

    // Oversized length: sticky error, no writes, then recovery.
    pulse_reload();
    load_stream(16'd600, empty_q, 1'b0, -1);
    check("len_err", {31'b0, err}, 32'd1);
    check("len_err_in_ready", {31'b0, in_ready}, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("len_err_sticky", {31'b0, err}, 32'd1);
    check("len_err_working", {31'b0, working}, 32'd0);
    pulse_reload();
    load_stream(16'd1, one_q, 1'b0, -1);
    check_done("after_err");

    // Reset after 13 data bytes aborts the load; a full reload then works.
    pulse_reload();
    load_stream(16'd9, prog, 1'b0, 13);
    rst_n = 1'b0;
    @(posedge clock);
    #1;
    check_reset_values("midreset");
    check("midreset_sb_empty", sb_q.size(), 32'd0);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    check("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    load_stream(16'd9, prog, 1'b0, -1);
    check_done("after_midreset");

    // Reload from DONE with a one-word program.
    pulse_reload();
    load_stream(16'd1, one_q, 1'b0, -1);
    check_done("reload_one");

    repeat (3) @(posedge clock);
    #1;
    check("final_sb_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
